// File: rtl/display_mux_nseg.sv
//============================================================================
// Module   : display_mux_nseg
// Purpose  : Time-multiplexed driver for NUM_DIGITS common-anode 7-segment
//            digits. Hex decode, per-digit decimal point, per-digit
//            blanking, dead-time guard between digits, PWM brightness and
//            frame-synchronous double buffering (no tearing).
// Options  : define LZ_SUPPRESS_EN to blank leading zero digits when a new
//            value is copied into the displayed (active) buffer.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module display_mux_nseg #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1350,
    parameter int GUARD_CYC   = 16,
    parameter int PWM_BITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anodo,
    output logic [6:0]              seven,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    pending
);

    //------------------------------------------------------------------------
    // Derived constants
    //------------------------------------------------------------------------
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    //------------------------------------------------------------------------
    // Scan state
    //------------------------------------------------------------------------
    logic [SLOT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_edge;

    // Double buffer: shadow takes loads, active feeds the decoder
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [NUM_DIGITS-1:0]   active_blank;

    // Blank masks as they should land in the active buffer
    logic [NUM_DIGITS-1:0]   load_blank_eff;
    logic [NUM_DIGITS-1:0]   shadow_blank_eff;

    // Currently scanned digit
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   anode_sel;
    logic [6:0]              cur_seg;
    logic                    bright_full;
    logic                    anode_on;

    // Last cycle of the last digit slot: the frame boundary edge
    assign frame_edge = (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);

    //------------------------------------------------------------------------
    // Hex to active-low segment pattern {g,f,e,d,c,b,a}
    //------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

`ifdef LZ_SUPPRESS_EN
    //------------------------------------------------------------------------
    // Leading-zero suppression: walk from the most significant digit down,
    // blanking zeros until a nonzero nibble or a lit decimal point is met.
    // Digit 0 always stays visible so a value of zero still shows "0".
    //------------------------------------------------------------------------
    function automatic logic [NUM_DIGITS-1:0] lz_blank(
        input logic [4*NUM_DIGITS-1:0] v,
        input logic [NUM_DIGITS-1:0]   d,
        input logic [NUM_DIGITS-1:0]   b
    );
        logic [NUM_DIGITS-1:0] r;
        logic                  sup;
        r   = b;
        sup = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (sup && (v[4*k +: 4] == 4'h0) && !d[k]) begin
                r[k] = 1'b1;
            end else begin
                sup = 1'b0;
            end
        end
        return r;
    endfunction

    assign load_blank_eff   = lz_blank(value, dp_in, blank_mask);
    assign shadow_blank_eff = lz_blank(shadow_val, shadow_dp, shadow_blank);
`else
    // Zeros always display; only the explicit mask blanks a digit
    assign load_blank_eff   = blank_mask;
    assign shadow_blank_eff = shadow_blank;
`endif

    //------------------------------------------------------------------------
    // Slot counter, digit index and free-running PWM counter
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    //------------------------------------------------------------------------
    // Shadow/active buffers: loads land in shadow, shadow moves to active
    // only on the frame boundary; a load on the boundary goes straight in.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_val   <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '1;
            active_val   <= '0;
            active_dp    <= '0;
            active_blank <= '1;
            pending      <= 1'b0;
        end else if (frame_edge) begin
            if (load) begin
                shadow_val   <= value;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_mask;
                active_val   <= value;
                active_dp    <= dp_in;
                active_blank <= load_blank_eff;
                pending      <= 1'b0;
            end else if (pending) begin
                active_val   <= shadow_val;
                active_dp    <= shadow_dp;
                active_blank <= shadow_blank_eff;
                pending      <= 1'b0;
            end
        end else if (load) begin
            // Last load before the boundary wins
            shadow_val   <= value;
            shadow_dp    <= dp_in;
            shadow_blank <= blank_mask;
            pending      <= 1'b1;
        end
    end

    //------------------------------------------------------------------------
    // Select nibble, dp, blank and anode position for the scanned digit
    //------------------------------------------------------------------------
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        anode_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib      = active_val[4*k +: 4];
                cur_dp       = active_dp[k];
                cur_blank    = active_blank[k];
                anode_sel[k] = 1'b0;
            end
        end
    end

    // Anode may be lit after the guard time and inside the PWM duty window
    assign bright_full = &brightness;
    assign anode_on    = (slot_cnt >= GUARD_END) &&
                         (bright_full || (pwm_cnt < brightness));
    assign cur_seg     = hex_to_seg(cur_nib);

    //------------------------------------------------------------------------
    // Registered pins: anode, segments and dp all move on the same edge
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anodo      <= '1;
            seven      <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            anodo      <= anode_on ? anode_sel : '1;
            seven      <= cur_blank ? SEG_OFF : cur_seg;
            dp         <= cur_blank ? 1'b1 : ~cur_dp;
            frame_done <= frame_edge;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_mux_nseg.sv
//============================================================================
// Module   : tb_display_mux_nseg
// Purpose  : Scoreboard bench for display_mux_nseg (4 digits, 8-cycle slots,
//            2-cycle guard). Stimulus pushes per-slot expectations; a monitor
//            aligned to frame_done summarises each slot on the pins and pops.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_display_mux_nseg;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;
    localparam int PB = 4;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0001110;
    localparam logic [6:0] SOFF = 7'h7F;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_mask = '0;
    logic [PB-1:0] brightness = 4'hF;
    logic [3:0]    anodo;
    logic [6:0]    seven;
    logic          dp;
    logic          frame_done;
    logic          pending;

    display_mux_nseg #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .GUARD_CYC  (GC),
        .PWM_BITS   (PB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_mask(blank_mask),
        .brightness(brightness),
        .anodo     (anodo),
        .seven     (seven),
        .dp        (dp),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // One expected digit slot as seen on the pins
    typedef struct {
        string      tag;
        logic [3:0] an;     // anode value while lit (4'hF if never lit)
        int         lows;   // number of lit cycles in the slot
        logic [6:0] seg;
        logic       dpv;
    } slot_exp_t;

    slot_exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push four slot expectations for the next frame; segs = {d3,d2,d1,d0}
    task automatic push_frame(input string tag, input logic [27:0] segs,
                              input logic [3:0] dps, input int lows_even,
                              input int lows_odd);
        slot_exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.tag  = $sformatf("%s_d%0d", tag, d);
            e.lows = (d % 2 == 0) ? lows_even : lows_odd;
            e.an   = 4'hF;
            if (e.lows > 0) e.an[d] = 1'b0;
            e.seg  = segs[7*d +: 7];
            e.dpv  = dps[d];
            sb.push_back(e);
        end
    endtask

    // Return at the negedge where frame_done is high (bounded)
    task automatic wait_frame();
        int t;
        t = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (frame_done !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done required within 200 cycles");
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value      = v;
        dp_in      = d;
        blank_mask = b;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Monitor: summarise each 8-cycle slot on the pins after frame_done
    initial begin
        int         k;
        int         lows;
        logic [3:0] lowv;
        bit         in_frame;
        slot_exp_t  e;
        in_frame = 0;
        k        = 0;
        lows     = 0;
        lowv     = 4'hF;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                in_frame = 0;
                k        = 0;
                lows     = 0;
                lowv     = 4'hF;
            end else begin
                if (in_frame) begin
                    k++;
                    if (anodo !== 4'hF) begin
                        lows++;
                        lowv = anodo;
                    end
                    if (k % 8 == 0) begin
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check({e.tag, "_anode"}, lowv, e.an);
                            check({e.tag, "_lit_cycles"}, lows, e.lows);
                            check({e.tag, "_seven"}, seven, e.seg);
                            check({e.tag, "_dp"}, dp, e.dpv);
                        end
                        lows = 0;
                        lowv = 4'hF;
                    end
                    if (k == 32 || frame_done === 1'b1) begin
                        check("frame_period_cycles", k, 32);
                        check("frame_done_on_period", frame_done, 1'b1);
                        in_frame = 0;
                    end
                end
                if (frame_done === 1'b1) begin
                    in_frame = 1;
                    k        = 0;
                    lows     = 0;
                    lowv     = 4'hF;
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_anodo", anodo, 4'hF);
        check("reset_seven", seven, SOFF);
        check("reset_dp", dp, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_pending", pending, 1'b0);
        rst = 1'b1;

        // Dark display until the first load
        wait_frame(); #2;
        push_frame("blank", {SOFF, SOFF, SOFF, SOFF}, 4'b1111, 6, 6);

        // Single load, shown on the following frame
        repeat (3) @(negedge clk);
        do_load(16'h12AF, 4'b0100, 4'b0000);
        check("pending_after_load", pending, 1'b1);
        repeat (10) @(negedge clk);
        check("pending_held", pending, 1'b1);
        wait_frame();
        check("pending_cleared", pending, 1'b0);
        #2;
        push_frame("v12AF", {S1, S2, SA, SF}, 4'b1011, 6, 6);

        // Two loads in one frame: last one wins
        repeat (2) @(negedge clk);
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000);
        check("pending_two_loads", pending, 1'b1);
        wait_frame();
        check("pending_cleared2", pending, 1'b0);
        #2;
        push_frame("v2222", {S2, S2, S2, S2}, 4'b1111, 6, 6);

        // Load sampled exactly on the boundary edge
        repeat (31) @(negedge clk);
        value      = 16'h80A8;
        dp_in      = 4'b0001;
        blank_mask = 4'b0000;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("boundary_frame_done", frame_done, 1'b1);
        check("boundary_pending", pending, 1'b0);
        #2;
        push_frame("v80A8", {S8, S0, SA, S8}, 4'b1110, 6, 6);

        // brightness 4: even slots see PWM 2..7 (2 lit), odd see 10..15
        wait_frame();
        brightness = 4'h4;
        #2;
        push_frame("pwm4", {S8, S0, SA, S8}, 4'b1110, 2, 0);

        wait_frame();
        brightness = 4'h0;
        #2;
        push_frame("pwm0", {S8, S0, SA, S8}, 4'b1110, 0, 0);

        // Reset mid-slot with a pending update
        wait_frame();
        brightness = 4'hF;
        repeat (3) @(negedge clk);
        do_load(16'h3333, 4'b1111, 4'b0000);
        check("pending_before_reset", pending, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_anodo", anodo, 4'hF);
        check("midreset_seven", seven, SOFF);
        check("midreset_dp", dp, 1'b1);
        check("midreset_pending", pending, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_frame(); #2;
        push_frame("after_reset", {SOFF, SOFF, SOFF, SOFF}, 4'b1111, 6, 6);

        // blank_mask darkens digit 1 but its anode still scans
        do_load(16'h4321, 4'b0010, 4'b0010);
        wait_frame(); #2;
        push_frame("mask", {S4, S3, SOFF, S1}, 4'b1111, 6, 6);

        // Zero handling
        do_load(16'h0050, 4'b0000, 4'b0000);
        wait_frame(); #2;
`ifdef LZ_SUPPRESS_EN
        push_frame("v0050", {SOFF, SOFF, S5, S0}, 4'b1111, 6, 6);
`else
        push_frame("v0050", {S0, S0, S5, S0}, 4'b1111, 6, 6);
`endif
        do_load(16'h0000, 4'b0000, 4'b0000);
        wait_frame(); #2;
`ifdef LZ_SUPPRESS_EN
        push_frame("v0000", {SOFF, SOFF, SOFF, S0}, 4'b1111, 6, 6);
`else
        push_frame("v0000", {S0, S0, S0, S0}, 4'b1111, 6, 6);
`endif
        do_load(16'h0000, 4'b0100, 4'b0000);
        wait_frame(); #2;
`ifdef LZ_SUPPRESS_EN
        push_frame("v0000dp", {SOFF, S0, S0, S0}, 4'b1011, 6, 6);
`else
        push_frame("v0000dp", {S0, S0, S0, S0}, 4'b1011, 6, 6);
`endif

        wait_frame();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test required before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/display_mux_nseg.md
Name: display_mux_nseg

Overview:
Parametrised time-multiplexed driver for common-anode 7-segment displays with NUM_DIGITS digits, hex decode and per-digit decimal points. It double-buffers the displayed value so that updates take effect only at frame boundaries, which prevents tearing. It also inserts a dead-time guard between digits against ghosting and applies PWM brightness control. It sits between the datapath (counters, switch readers) and the board display pins, and supersedes the fixed 4-digit scanner.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
REFRESH_DIV, 1350, clock cycles per digit slot (>= GUARD_CYC+2).
GUARD_CYC, 16, cycles at the start of each slot with all anodes off.
PWM_BITS, 4, width of the brightness control.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active low.
load  in  1  single-cycle strobe that captures value/dp_in/blank_mask.
value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]; digit 0 is rightmost.
dp_in  in  NUM_DIGITS  decimal point enable per digit, active high.
blank_mask  in  NUM_DIGITS  1 = force digit k dark.
brightness  in  PWM_BITS  0 = dark, all-ones = full on.
anodo  out  NUM_DIGITS  anode enables, active low.
seven  out  7  segments {g,f,e,d,c,b,a}, active low.
dp  out  1  decimal point segment, active low.
frame_done  out  1  one-cycle pulse at the end of each full scan.
pending  out  1  high while the shadow buffer holds data not yet displayed.

Behaviour:
- Reset is asynchronous and active low; clock is clk.
- Reset state:
  - anodo all ones; seven = 7'h7F; dp = 1; frame_done = 0; pending = 0.
  - Slot counter = 0; digit index = 0; PWM counter = 0.
  - Shadow and active buffers cleared to 0; blank_mask buffers cleared to all ones, so the display is dark until the first load.
- Scan:
  - Slot counter runs 0..REFRESH_DIV-1. On wrap, the digit index increments modulo NUM_DIGITS.
  - Each slot has a GUARD phase (counter < GUARD_CYC, all anodes off) followed by an ON phase.
- PWM:
  - A free-running PWM_BITS counter runs continuously.
  - During the ON phase, the anode for the current index is driven low when the PWM counter < brightness, or when brightness is all ones.
  - brightness = 0 gives permanently dark anodes.
- Decode: standard hex table from the active buffer nibble of the current index.
  - 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
  - A blanked digit drives seven = 7'h7F and dp = 1; its anode still follows the scan.
  - dp = ~dp_active[index].
- Output timing: all outputs are registered. Pins reflect counter/index state with a fixed 1-cycle latency, so anode, seven and dp always change on the same edge.
- Buffering:
  - A load pulse writes the shadow buffer and sets pending.
  - A second load before the frame boundary overwrites the shadow; the last load wins.
- Frame boundary: the edge where index wraps NUM_DIGITS-1 -> 0.
  - frame_done pulses for one cycle.
  - If pending is set, shadow is copied to active and pending clears.
  - If load coincides with the boundary, the incoming value goes directly to active and pending stays 0.
- Mid-operation reset: returns immediately to the reset state; no partial update reaches active.

Optional Feature:
LZ_SUPPRESS_EN:
- When defined, the blanking logic computes suppression at the copy into active.
  - Leading zero digits (most significant downward, stopping at the first nonzero nibble) are additionally blanked.
  - Digit 0 is never suppressed.
  - A digit whose dp_in is set stops suppression at that digit.
- When undefined, zeros always display and only blank_mask blanks.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2, brightness=4'hF.
- Reset release, no load -> anodo cycles 1110/1101/1011/0111, each low 6 of 8 cycles, seven = 7F throughout; frame_done every 32 cycles.
- load value=16'h12AF, dp_in=4'b0100, blank_mask=0 -> pending=1 until the next frame_done.
  - Next frame shows F, A, 2, 1 on digits 0..3.
  - dp low only while anodo=1011.
- Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 is displayed; a load on the boundary cycle shows in the immediately following frame with pending=0.
- brightness=4'h4 -> within each ON phase the anode is low exactly when the PWM counter is 0..3; brightness=0 -> anodo stays 1111.
- Assert rst mid-slot while pending=1 -> outputs return at once to 1111/7F/1, pending=0, and the display is blank after release.
- With LZ_SUPPRESS_EN: value=16'h0050 -> digits 3 and 2 are dark; digit 1 shows 5; digit 0 shows 0. value=16'h0000 -> only digit 0 shows 0.
